// File: rtl/atmega_pkg.sv
// Shared definitions for the interrupt vector controller: FSM encoding and
// the offset that keeps vector 0 reserved for the reset vector.
package atmega_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CLR     = 2'd2,
    SERVICE = 2'd3
  } state_t;

  localparam int VECT_OFFSET = 1;

endpackage

// File: rtl/int_vect_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 is the most urgent request.
module prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_vect_ctrl.sv
// Non-nesting interrupt vector controller: arbitrates level requests, presents
// a vector to the CPU, pulses the serviced source's clear, tracks in-service.
module int_vect_ctrl
  import atmega_pkg::*;
#(
  parameter int NUM_IRQ    = 8,
  parameter int VECT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [NUM_IRQ-1:0]    irq_en,
  input  logic                  gie,
  output logic                  cpu_irq,
  output logic [VECT_WIDTH-1:0] cpu_vect,
  input  logic                  cpu_ack,
  input  logic                  cpu_reti,
  output logic [NUM_IRQ-1:0]    irq_clr,
  output logic                  in_service,
  output state_t                state
);

  // Handshake: cpu_irq/cpu_vect form a request held stable until the CPU
  // answers with a one-cycle cpu_ack; cpu_reti closes the service window.
  // Strobes arriving in any other state have no effect.

  logic [NUM_IRQ-1:0]    pending;
  logic [NUM_IRQ-1:0]    win_mask;
  logic [VECT_WIDTH-1:0] win_idx;
  logic                  win_valid;
  logic [NUM_IRQ-1:0]    sel_mask;
  logic                  sel_enabled;
  logic                  sel_line;

  assign pending     = gie ? (irq_in & irq_en) : '0;
  // Isolate the lowest set bit so the clear pulse is one-hot by construction.
  assign win_mask    = pending & (~pending + NUM_IRQ'(1));
  assign sel_enabled = |(irq_en & sel_mask);
  assign sel_line    = |(irq_in & sel_mask);

  prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (VECT_WIDTH)
  ) u_prio_enc (
    .req   (pending),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_irq    <= 1'b0;
      cpu_vect   <= '0;
      irq_clr    <= '0;
      in_service <= 1'b0;
      sel_mask   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= REQ;
            sel_mask <= win_mask;
            cpu_irq  <= 1'b1;
            cpu_vect <= win_idx + VECT_WIDTH'(VECT_OFFSET);
          end
        end
        REQ: begin
          // Ack wins over a simultaneous withdrawal.
          if (cpu_ack) begin
            state      <= CLR;
            cpu_irq    <= 1'b0;
            cpu_vect   <= '0;
            irq_clr    <= sel_mask;
            in_service <= 1'b1;
          end else if (!sel_enabled || !gie) begin
            state    <= IDLE;
            cpu_irq  <= 1'b0;
            cpu_vect <= '0;
          end
        end
        CLR: begin
          irq_clr <= '0;
          if (!sel_line) begin
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (cpu_reti) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_vect_ctrl.sv
// Self-checking bench for int_vect_ctrl: directed scenarios with a vector and
// clear-pulse scoreboard drained every falling edge.
module tb_int_vect_ctrl;
  import atmega_pkg::*;

  localparam int NUM_IRQ    = 8;
  localparam int VECT_WIDTH = 5;

  logic                  clk;
  logic                  rst;
  logic [NUM_IRQ-1:0]    irq_in;
  logic [NUM_IRQ-1:0]    irq_en;
  logic                  gie;
  logic                  cpu_irq;
  logic [VECT_WIDTH-1:0] cpu_vect;
  logic                  cpu_ack;
  logic                  cpu_reti;
  logic [NUM_IRQ-1:0]    irq_clr;
  logic                  in_service;
  state_t                state;

  int checks = 0;
  int errors = 0;
  logic                  irq_q = 1'b0;
  logic [VECT_WIDTH-1:0] exp_vect_q[$];
  logic [NUM_IRQ-1:0]    exp_clr_q[$];

  int_vect_ctrl #(
    .NUM_IRQ    (NUM_IRQ),
    .VECT_WIDTH (VECT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .irq_en     (irq_en),
    .gie        (gie),
    .cpu_irq    (cpu_irq),
    .cpu_vect   (cpu_vect),
    .cpu_ack    (cpu_ack),
    .cpu_reti   (cpu_reti),
    .irq_clr    (irq_clr),
    .in_service (in_service),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge and drain the scoreboard.
  task automatic tick();
    logic [VECT_WIDTH-1:0] ev;
    logic [NUM_IRQ-1:0]    ec;
    @(negedge clk);
    if (cpu_irq === 1'b1 && irq_q !== 1'b1) begin
      checks++;
      if (exp_vect_q.size() == 0) begin
        errors++;
        $display("FAIL vect_unexpected got=%0d expected=none", cpu_vect);
      end else begin
        ev = exp_vect_q.pop_front();
        if (cpu_vect !== ev) begin
          errors++;
          $display("FAIL vect_value got=%0d expected=%0d", cpu_vect, ev);
        end
      end
    end
    if (irq_clr !== '0) begin
      checks++;
      if (exp_clr_q.size() == 0) begin
        errors++;
        $display("FAIL clr_unexpected got=%h expected=none", irq_clr);
      end else begin
        ec = exp_clr_q.pop_front();
        if (irq_clr !== ec) begin
          errors++;
          $display("FAIL clr_value got=%h expected=%h", irq_clr, ec);
        end
      end
    end
    irq_q = cpu_irq;
  endtask

  task automatic wait_irq(input string name);
    int n = 0;
    while (cpu_irq !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (cpu_irq !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout got cpu_irq=%b expected=1", name, cpu_irq);
    end
  endtask

  task automatic pulse_ack();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = '0; irq_en = '0; gie = 1'b0; cpu_ack = 1'b0; cpu_reti = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (cpu_irq !== 1'b0 || cpu_vect !== '0 || irq_clr !== '0 || in_service !== 1'b0 || state !== IDLE) begin
      errors++;
      $display("FAIL reset got irq=%b vect=%0d clr=%h isv=%b st=%0d expected all 0", cpu_irq, cpu_vect, irq_clr, in_service, state);
    end
  endtask

  task automatic test_single();
    irq_en = 8'hFF; gie = 1'b1;
    exp_vect_q.push_back(5'd3);
    irq_in = 8'h04;
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || state !== REQ) begin
      errors++;
      $display("FAIL single_latency got irq=%b st=%0d expected irq=1 st=REQ", cpu_irq, state);
    end
    exp_clr_q.push_back(8'h04);
    pulse_ack();
    checks++;
    if (in_service !== 1'b1 || state !== CLR || cpu_irq !== 1'b0) begin
      errors++;
      $display("FAIL single_ack got isv=%b st=%0d irq=%b expected isv=1 st=CLR irq=0", in_service, state, cpu_irq);
    end
    // Source line lingers: CLR must hold without re-pulsing.
    tick(); tick();
    checks++;
    if (state !== CLR || irq_clr !== '0) begin
      errors++;
      $display("FAIL single_clr_hold got st=%0d clr=%h expected st=CLR clr=0", state, irq_clr);
    end
    irq_in = 8'h00;
    tick();
    checks++;
    if (state !== SERVICE || in_service !== 1'b1) begin
      errors++;
      $display("FAIL single_service got st=%0d isv=%b expected SERVICE 1", state, in_service);
    end
    pulse_reti();
    checks++;
    if (state !== IDLE || in_service !== 1'b0) begin
      errors++;
      $display("FAIL single_reti got st=%0d isv=%b expected IDLE 0", state, in_service);
    end
  endtask

  task automatic test_priority();
    exp_vect_q.push_back(5'd5);
    irq_in = 8'h90;
    wait_irq("prio_first");
    exp_clr_q.push_back(8'h10);
    pulse_ack();
    irq_in = 8'h80;
    tick();
    pulse_reti();
    exp_vect_q.push_back(5'd8);
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_vect !== 5'd8) begin
      errors++;
      $display("FAIL prio_rearb got irq=%b vect=%0d expected 1 8", cpu_irq, cpu_vect);
    end
    // A more urgent source arriving mid-request must not steal the slot.
    irq_in = 8'h82;
    tick();
    checks++;
    if (cpu_vect !== 5'd8 || state !== REQ) begin
      errors++;
      $display("FAIL prio_stable got vect=%0d st=%0d expected 8 REQ", cpu_vect, state);
    end
    exp_clr_q.push_back(8'h80);
    pulse_ack();
    irq_in = 8'h02;
    tick();
    exp_vect_q.push_back(5'd2);
    pulse_reti();
    wait_irq("prio_second");
    exp_clr_q.push_back(8'h02);
    pulse_ack();
    irq_in = 8'h00;
    tick();
    pulse_reti();
  endtask

  task automatic test_withdraw();
    exp_vect_q.push_back(5'd3);
    irq_in = 8'h04;
    wait_irq("wd_en");
    irq_en = 8'hFB;
    tick();
    checks++;
    if (cpu_irq !== 1'b0 || state !== IDLE || irq_clr !== '0 || in_service !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_en got irq=%b st=%0d clr=%h isv=%b expected 0 IDLE 0 0", cpu_irq, state, irq_clr, in_service);
    end
    exp_vect_q.push_back(5'd3);
    irq_en = 8'hFF;
    wait_irq("wd_gie");
    gie = 1'b0;
    tick();
    checks++;
    if (cpu_irq !== 1'b0 || state !== IDLE) begin
      errors++;
      $display("FAIL withdraw_gie got irq=%b st=%0d expected 0 IDLE", cpu_irq, state);
    end
    tick();
    gie = 1'b1;
    exp_vect_q.push_back(5'd3);
    wait_irq("wd_race");
    // Ack and withdrawal together: the ack wins.
    irq_en = 8'hFB;
    exp_clr_q.push_back(8'h04);
    pulse_ack();
    checks++;
    if (state !== CLR || in_service !== 1'b1) begin
      errors++;
      $display("FAIL ack_beats_withdraw got st=%0d isv=%b expected CLR 1", state, in_service);
    end
    irq_en = 8'hFF;
    irq_in = 8'h00;
    tick();
    pulse_reti();
  endtask

  task automatic test_ignored();
    cpu_ack = 1'b1; cpu_reti = 1'b1;
    tick();
    cpu_ack = 1'b0; cpu_reti = 1'b0;
    checks++;
    if (state !== IDLE || in_service !== 1'b0 || irq_clr !== '0) begin
      errors++;
      $display("FAIL idle_strobes got st=%0d isv=%b clr=%h expected IDLE 0 0", state, in_service, irq_clr);
    end
    exp_vect_q.push_back(5'd6);
    irq_in = 8'h20;
    wait_irq("ign");
    exp_clr_q.push_back(8'h20);
    pulse_ack();
    pulse_reti();
    checks++;
    if (state !== CLR || in_service !== 1'b1) begin
      errors++;
      $display("FAIL clr_reti got st=%0d isv=%b expected CLR 1", state, in_service);
    end
    irq_in = 8'h00;
    tick();
    pulse_ack();
    checks++;
    if (state !== SERVICE || irq_clr !== '0) begin
      errors++;
      $display("FAIL service_ack got st=%0d clr=%h expected SERVICE 0", state, irq_clr);
    end
    pulse_reti();
  endtask

  task automatic test_timer();
    int cnt = 0;
    int clr_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (cnt == 0) begin
        irq_in[0] = 1'b1;
        exp_vect_q.push_back(5'd1);
        exp_clr_q.push_back(8'h01);
      end
      cnt = (cnt + 1) % 10;
      tick();
      cpu_ack  = cpu_irq;
      cpu_reti = (state == SERVICE);
      if (irq_clr[0]) begin
        irq_in[0] = 1'b0;
        clr_seen++;
      end
    end
    cpu_ack = 1'b0; cpu_reti = 1'b0;
    tick(); tick();
    checks++;
    if (clr_seen != 4 || state !== IDLE) begin
      errors++;
      $display("FAIL timer_periods got clr=%0d st=%0d expected 4 IDLE", clr_seen, state);
    end
  endtask

  task automatic test_hold_off();
    exp_vect_q.push_back(5'd4);
    irq_in = 8'h08;
    wait_irq("hold");
    exp_clr_q.push_back(8'h08);
    pulse_ack();
    irq_in = 8'h00;
    tick();
    irq_in = 8'h01;
    tick(); tick(); tick();
    checks++;
    if (cpu_irq !== 1'b0 || state !== SERVICE) begin
      errors++;
      $display("FAIL hold_off got irq=%b st=%0d expected 0 SERVICE", cpu_irq, state);
    end
    exp_vect_q.push_back(5'd1);
    pulse_reti();
    tick();
    checks++;
    if (cpu_irq !== 1'b1 || cpu_vect !== 5'd1) begin
      errors++;
      $display("FAIL hold_release got irq=%b vect=%0d expected 1 1", cpu_irq, cpu_vect);
    end
    exp_clr_q.push_back(8'h01);
    pulse_ack();
    irq_in = 8'h00;
    tick();
    pulse_reti();
  endtask

  task automatic test_reset_mid();
    exp_vect_q.push_back(5'd3);
    irq_in = 8'h04;
    wait_irq("rst_clr");
    exp_clr_q.push_back(8'h04);
    pulse_ack();
    rst = 1'b1;
    irq_in = 8'h00;
    tick();
    rst = 1'b0;
    checks++;
    if (cpu_irq !== 1'b0 || cpu_vect !== '0 || irq_clr !== '0 || in_service !== 1'b0 || state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_clr got irq=%b vect=%0d clr=%h isv=%b st=%0d expected all 0", cpu_irq, cpu_vect, irq_clr, in_service, state);
    end
    exp_vect_q.push_back(5'd2);
    irq_in = 8'h02;
    wait_irq("rst_req");
    rst = 1'b1;
    irq_in = 8'h00;
    tick();
    rst = 1'b0;
    checks++;
    if (cpu_irq !== 1'b0 || state !== IDLE || irq_clr !== '0) begin
      errors++;
      $display("FAIL reset_mid_req got irq=%b st=%0d clr=%h expected 0 IDLE 0", cpu_irq, state, irq_clr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_withdraw();
    test_ignored();
    test_timer();
    test_hold_off();
    test_reset_mid();
    checks++;
    if (exp_vect_q.size() != 0 || exp_clr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got vect_left=%0d clr_left=%0d expected 0 0", exp_vect_q.size(), exp_clr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
